// File: rtl/stream_sched_rr.sv
// Round-robin scheduler sharing one fixed-latency datapath between N_REQ valid/ready streams.
// Each issued operand carries a one-hot tag down a pipeline so its result returns to its owner.
module stream_sched_rr #(
   parameter int WIDTH   = 16,
   parameter int N_REQ   = 3,
   parameter int LATENCY = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic [N_REQ-1:0]       req_mask,
   input  logic [N_REQ-1:0]       req_valid,
   input  logic [N_REQ*WIDTH-1:0] req_data,
   output logic [N_REQ-1:0]       req_ready,
   output logic                   dp_valid,
   output logic [WIDTH-1:0]       dp_data,
   input  logic [WIDTH-1:0]       dp_result,
   output logic [N_REQ-1:0]       rsp_valid,
   output logic [WIDTH-1:0]       rsp_data,
   output logic                   idle
);

   localparam int PTR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int STAGES = LATENCY + 1;

   logic [PTR_W-1:0] rr_ptr_reg;
   logic [PTR_W-1:0] rr_ptr_next;
   logic             dp_valid_reg;
   logic [WIDTH-1:0] dp_data_reg;

   logic [N_REQ-1:0] eligible;
   logic [N_REQ-1:0] grant_onehot;
   logic [PTR_W-1:0] grant_idx;
   logic             grant_any;
   logic [PTR_W:0]   scan_idx;

   logic [STAGES-1:0] stage_valid;
   logic [N_REQ-1:0]  stage_tag [STAGES];

   // Reset also blocks grants so no handshake completes while rst is high.
   assign eligible = req_valid & ~req_mask & {N_REQ{en & ~rst}};

   // Circular search starting at rr_ptr; the scan index is one bit wider so it can wrap.
   always_comb begin
      grant_onehot = '0;
      grant_idx    = '0;
      grant_any    = 1'b0;
      scan_idx     = '0;
      for (int k = 0; k < N_REQ; k++) begin
         scan_idx = {1'b0, rr_ptr_reg} + (PTR_W + 1)'(k);
         if (scan_idx >= (PTR_W + 1)'(N_REQ)) begin
            scan_idx = scan_idx - (PTR_W + 1)'(N_REQ);
         end
         if (!grant_any && eligible[scan_idx[PTR_W-1:0]]) begin
            grant_any = 1'b1;
            grant_idx = scan_idx[PTR_W-1:0];
         end
      end
      if (grant_any) begin
         grant_onehot[grant_idx] = 1'b1;
      end
   end

   always_comb begin
      rr_ptr_next = rr_ptr_reg;
      if (grant_any) begin
         rr_ptr_next = (grant_idx == PTR_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_reg   <= '0;
         dp_valid_reg <= 1'b0;
         dp_data_reg  <= '0;
      end else begin
         rr_ptr_reg   <= rr_ptr_next;
         dp_valid_reg <= grant_any;
         if (grant_any) begin
            dp_data_reg <= req_data[grant_idx*WIDTH +: WIDTH];
         end
      end
   end

   // Tag pipeline: stage 0 lines up with dp_valid, stage LATENCY with dp_result.
   genvar gi;
   generate
      for (gi = 0; gi < STAGES; gi++) begin : g_tag
         logic             in_valid;
         logic [N_REQ-1:0] in_tag;
         logic             valid_reg;
         logic [N_REQ-1:0] tag_reg;

         if (gi == 0) begin : g_head
            assign in_valid = grant_any;
            assign in_tag   = grant_onehot;
         end else begin : g_body
            assign in_valid = stage_valid[gi-1];
            assign in_tag   = stage_tag[gi-1];
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               valid_reg <= 1'b0;
               tag_reg   <= '0;
            end else begin
               valid_reg <= in_valid;
               tag_reg   <= in_tag;
            end
         end

         assign stage_valid[gi] = valid_reg;
         assign stage_tag[gi]   = tag_reg;
      end
   endgenerate

   assign req_ready = grant_onehot;
   assign dp_valid  = dp_valid_reg;
   assign dp_data   = dp_data_reg;
   assign rsp_valid = stage_valid[LATENCY] ? stage_tag[LATENCY] : '0;
   assign rsp_data  = dp_result;
   assign idle      = (eligible == '0) && (stage_valid == '0) && !dp_valid_reg;

endmodule

// File: tb/tb_stream_sched_rr.sv
// Bench for stream_sched_rr: scenario tasks plus a randomized run, all checked against
// a transaction-level model (distance-from-pointer grant rule and a queue of due responses).
module tb_stream_sched_rr;

   localparam int N   = 3;
   localparam int W   = 16;
   localparam int LAT = 2;

   logic           clk;
   logic           rst;
   logic           en;
   logic [N-1:0]   req_mask;
   logic [N-1:0]   req_valid;
   logic [N*W-1:0] req_data;
   logic [N-1:0]   req_ready;
   logic           dp_valid;
   logic [W-1:0]   dp_data;
   logic [W-1:0]   dp_result;
   logic [N-1:0]   rsp_valid;
   logic [W-1:0]   rsp_data;
   logic           idle;

   stream_sched_rr #(.WIDTH(W), .N_REQ(N), .LATENCY(LAT)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .req_mask  (req_mask),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .dp_valid  (dp_valid),
      .dp_data   (dp_data),
      .dp_result (dp_result),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .idle      (idle)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [W-1:0] fdp(input logic [W-1:0] x);
      return x * 16'd3 + 16'd1;
   endfunction

   // Stand-in datapath: fixed LAT-cycle pipeline computing fdp(operand).
   logic [W-1:0] pipe [LAT];
   always @(posedge clk) begin
      pipe[0] <= fdp(dp_data);
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
   end
   assign dp_result = pipe[LAT-1];

   typedef struct {
      int           due;
      logic [N-1:0] tag;
      logic [W-1:0] res;
   } rec_t;

   int           checks = 0;
   int           errors = 0;
   int           cyc = 0;
   int           ptr = 0;
   logic         m_dp_valid = 1'b0;
   logic [W-1:0] m_dp_data = '0;
   rec_t         q[$];
   logic [N-1:0] e_now;
   int           exp_grant;
   logic [N-1:0] exp_ready;
   logic [N-1:0] exp_rsp_valid;
   logic [W-1:0] exp_rsp_data;
   logic         exp_idle;

   task automatic randomize_data();
      for (int i = 0; i < N; i++) req_data[i*W +: W] = W'($urandom);
   endtask

   // Expected outputs for the current cycle; grant = eligible requester nearest at/after ptr.
   task automatic model_eval();
      #1;
      e_now = rst ? '0 : (req_valid & ~req_mask & {N{en}});
      exp_grant = -1;
      for (int i = 0; i < N; i++) begin
         if (e_now[i] && (exp_grant < 0 || ((i - ptr + N) % N) < ((exp_grant - ptr + N) % N)))
            exp_grant = i;
      end
      exp_ready = '0;
      if (exp_grant >= 0) exp_ready[exp_grant] = 1'b1;
      exp_rsp_valid = '0;
      exp_rsp_data  = '0;
      foreach (q[j]) begin
         if (q[j].due == cyc) begin
            exp_rsp_valid = q[j].tag;
            exp_rsp_data  = q[j].res;
         end
      end
      exp_idle = (e_now == '0) && (q.size() == 0) && !m_dp_valid;
   endtask

   task automatic advance();
      logic [W-1:0] d;
      @(posedge clk);
      if (rst) begin
         ptr = 0;
         m_dp_valid = 1'b0;
         m_dp_data = '0;
         q.delete();
      end else begin
         while (q.size() > 0 && q[0].due <= cyc) q.delete(0);
         if (exp_grant >= 0) begin
            d = req_data[exp_grant*W +: W];
            ptr = (exp_grant + 1) % N;
            m_dp_valid = 1'b1;
            m_dp_data = d;
            q.push_back('{due: cyc + 1 + LAT, tag: exp_ready, res: fdp(d)});
         end else begin
            m_dp_valid = 1'b0;
         end
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      req_valid = '0;
      model_eval();
      advance();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b1; req_mask = '0; req_valid = '1;
      randomize_data();
      model_eval();
      advance();
      model_eval();
      checks++;
      if (req_ready !== 3'b000) begin
         errors++; $display("FAIL reset_ready got %b want %b", req_ready, 3'b000);
      end
      checks++;
      if (dp_valid !== 1'b0) begin
         errors++; $display("FAIL reset_dp_valid got %b want 0", dp_valid);
      end
      checks++;
      if (rsp_valid !== 3'b000) begin
         errors++; $display("FAIL reset_rsp_valid got %b want %b", rsp_valid, 3'b000);
      end
      checks++;
      if (dp_data !== 16'h0000) begin
         errors++; $display("FAIL reset_dp_data got %h want 0000", dp_data);
      end
      advance();
      rst = 1'b0; req_valid = '0;
      model_eval();
      checks++;
      if (idle !== 1'b1) begin
         errors++; $display("FAIL reset_idle got %b want 1", idle);
      end
      advance();
      $display("test_reset done checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_single();
      req_valid = 3'b010;
      req_data[1*W +: W] = 16'h00A5;
      model_eval();
      checks++;
      if (req_ready !== 3'b010) begin
         errors++; $display("FAIL single_ready got %b want %b", req_ready, 3'b010);
      end
      advance();
      req_valid = '0;
      model_eval();
      checks++;
      if (dp_valid !== 1'b1 || dp_data !== 16'h00A5) begin
         errors++; $display("FAIL single_issue got v=%b d=%h want v=1 d=00a5", dp_valid, dp_data);
      end
      checks++;
      if (rsp_valid !== 3'b000) begin
         errors++; $display("FAIL single_early_rsp got %b want %b", rsp_valid, 3'b000);
      end
      advance();
      model_eval();
      advance();
      model_eval();
      checks++;
      if (rsp_valid !== 3'b010) begin
         errors++; $display("FAIL single_rsp_valid got %b want %b", rsp_valid, 3'b010);
      end
      checks++;
      if (rsp_data !== fdp(16'h00A5)) begin
         errors++; $display("FAIL single_rsp_data got %h want %h", rsp_data, fdp(16'h00A5));
      end
      advance();
      model_eval();
      checks++;
      if (idle !== 1'b1) begin
         errors++; $display("FAIL single_idle got %b want 1", idle);
      end
      advance();
      $display("test_single done checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_round_robin();
      int order [6];
      order = '{0, 1, 2, 0, 1, 2};
      pulse_reset();
      req_valid = '1;
      for (int k = 0; k < 9; k++) begin
         if (k == 6) req_valid = '0;
         randomize_data();
         model_eval();
         if (k < 6) begin
            checks++;
            if (req_ready !== (3'b001 << order[k])) begin
               errors++; $display("FAIL rr_grant k=%0d got %b want %b", k, req_ready, 3'b001 << order[k]);
            end
         end
         if (k >= 1 && k <= 6) begin
            checks++;
            if (dp_valid !== 1'b1) begin
               errors++; $display("FAIL rr_dp_valid k=%0d got %b want 1", k, dp_valid);
            end
         end
         if (k >= 3) begin
            checks++;
            if (rsp_valid !== (3'b001 << order[k-3]) || rsp_data !== exp_rsp_data) begin
               errors++; $display("FAIL rr_rsp k=%0d got %b/%h want %b/%h", k, rsp_valid, rsp_data,
                                  3'b001 << order[k-3], exp_rsp_data);
            end
         end
         advance();
      end
      $display("test_round_robin done checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_mask_en();
      int order [4];
      order = '{0, 2, 0, 2};
      pulse_reset();
      req_mask = 3'b010; req_valid = '1; en = 1'b1;
      for (int k = 0; k < 4; k++) begin
         randomize_data();
         model_eval();
         checks++;
         if (req_ready !== (3'b001 << order[k])) begin
            errors++; $display("FAIL mask_grant k=%0d got %b want %b", k, req_ready, 3'b001 << order[k]);
         end
         advance();
      end
      en = 1'b0;
      for (int k = 0; k < 3; k++) begin
         model_eval();
         checks++;
         if (req_ready !== 3'b000) begin
            errors++; $display("FAIL en_low_grant k=%0d got %b want %b", k, req_ready, 3'b000);
         end
         checks++;
         if (rsp_valid !== (3'b001 << order[k+1]) || rsp_data !== exp_rsp_data) begin
            errors++; $display("FAIL en_low_rsp k=%0d got %b/%h want %b/%h", k, rsp_valid, rsp_data,
                               3'b001 << order[k+1], exp_rsp_data);
         end
         advance();
      end
      en = 1'b1;
      model_eval();
      checks++;
      if (req_ready !== 3'b001) begin
         errors++; $display("FAIL en_resume_grant got %b want %b", req_ready, 3'b001);
      end
      advance();
      // A requester masked while its op is in flight still gets the result.
      req_mask = '0; req_valid = 3'b010;
      model_eval();
      advance();
      req_mask = 3'b010; req_valid = '1;
      for (int k = 0; k < 3; k++) begin
         model_eval();
         if (k == 2) begin
            checks++;
            if (rsp_valid !== 3'b010) begin
               errors++; $display("FAIL masked_inflight_rsp got %b want %b", rsp_valid, 3'b010);
            end
         end
         advance();
      end
      req_mask = '0; req_valid = '0;
      for (int k = 0; k < 4; k++) begin model_eval(); advance(); end
      $display("test_mask_en done checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_midflight_reset();
      pulse_reset();
      req_valid = 3'b001; model_eval(); advance();
      req_valid = 3'b010; model_eval(); advance();
      req_valid = '0; rst = 1'b1; model_eval(); advance();
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         model_eval();
         checks++;
         if (rsp_valid !== 3'b000) begin
            errors++; $display("FAIL midflight_rsp k=%0d got %b want %b", k, rsp_valid, 3'b000);
         end
         advance();
      end
      req_valid = '1;
      model_eval();
      checks++;
      if (req_ready !== 3'b001) begin
         errors++; $display("FAIL midflight_next_grant got %b want %b", req_ready, 3'b001);
      end
      advance();
      req_valid = '0;
      for (int k = 0; k < 4; k++) begin model_eval(); advance(); end
      $display("test_midflight_reset done checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_wrap();
      pulse_reset();
      req_valid = 3'b100;
      model_eval();
      checks++;
      if (req_ready !== 3'b100) begin
         errors++; $display("FAIL wrap_first got %b want %b", req_ready, 3'b100);
      end
      advance();
      req_valid = 3'b101;
      model_eval();
      checks++;
      if (req_ready !== 3'b001) begin
         errors++; $display("FAIL wrap_second got %b want %b", req_ready, 3'b001);
      end
      advance();
      req_valid = '0;
      for (int k = 0; k < 4; k++) begin model_eval(); advance(); end
      $display("test_wrap done checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_random();
      int waitc [N];
      for (int i = 0; i < N; i++) waitc[i] = 0;
      for (int n = 0; n < 600; n++) begin
         rst       = ($urandom_range(0, 79) == 0);
         en        = ($urandom_range(0, 7) != 0);
         req_mask  = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
         req_valid = N'($urandom);
         randomize_data();
         model_eval();
         checks++;
         if (req_ready !== exp_ready) begin
            errors++; $display("FAIL rand_ready cyc=%0d got %b want %b", cyc, req_ready, exp_ready);
         end
         checks++;
         if (dp_valid !== m_dp_valid || dp_data !== m_dp_data) begin
            errors++; $display("FAIL rand_dp cyc=%0d got %b/%h want %b/%h", cyc, dp_valid, dp_data,
                               m_dp_valid, m_dp_data);
         end
         checks++;
         if (rsp_valid !== exp_rsp_valid) begin
            errors++; $display("FAIL rand_rsp_valid cyc=%0d got %b want %b", cyc, rsp_valid, exp_rsp_valid);
         end
         if (exp_rsp_valid != '0) begin
            checks++;
            if (rsp_data !== exp_rsp_data) begin
               errors++; $display("FAIL rand_rsp_data cyc=%0d got %h want %h", cyc, rsp_data, exp_rsp_data);
            end
         end
         checks++;
         if (idle !== exp_idle) begin
            errors++; $display("FAIL rand_idle cyc=%0d got %b want %b", cyc, idle, exp_idle);
         end
         for (int i = 0; i < N; i++) begin
            if (e_now[i] && req_ready[i] !== 1'b1) waitc[i]++;
            else waitc[i] = 0;
            if (e_now[i]) begin
               checks++;
               if (waitc[i] >= N) begin
                  errors++; $display("FAIL rand_fair cyc=%0d req=%0d waited %0d want <%0d", cyc, i, waitc[i], N);
               end
            end
         end
         advance();
      end
      rst = 1'b0; req_valid = '0;
      $display("test_random done checks=%0d errors=%0d", checks, errors);
   endtask

   initial begin
      rst = 1'b1; en = 1'b1; req_mask = '0; req_valid = '0; req_data = '0;
      @(negedge clk);
      test_reset();
      test_single();
      test_round_robin();
      test_mask_en();
      test_midflight_reset();
      test_wrap();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout simulation did not finish got t=%0t want <200000", $time);
      $fatal(1, "timeout");
   end

endmodule
